// File: rtl/serial_packet_demux_if.sv
// rtl/serial_packet_demux_if.sv - serial input and per-lane output bundle for serial_packet_demux
interface serial_packet_demux_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int LEN_W  = 4
);
    logic              ser_in;
    logic              abort;
    logic [NUM_CH-1:0] ser_out;
    logic [NUM_CH-1:0] ser_out_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic [CH_W-1:0]   cur_ch;
    logic [LEN_W-1:0]  cur_len;

    modport master (
        output ser_in, abort,
        input  ser_out, ser_out_valid, busy, done, err, cur_ch, cur_len
    );

    modport slave (
        input  ser_in, abort,
        output ser_out, ser_out_valid, busy, done, err, cur_ch, cur_len
    );
endinterface

// File: rtl/serial_packet_demux.sv
// rtl/serial_packet_demux.sv - sync hunt, header capture and payload routing to NUM_CH serial lanes
module serial_packet_demux #(
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1101,
    parameter int                NUM_CH   = 4,
    parameter int                CH_W     = $clog2(NUM_CH),
    parameter int                LEN_W    = 4
) (
    input  logic clk,
    input  logic rst,
    serial_packet_demux_if.slave bus
);
    localparam int HW     = CH_W + LEN_W;
    localparam int SCNT_W = $clog2(SYNC_W + 1);
    localparam int HCNT_W = $clog2(HW + 1);
    localparam int CHX_W  = CH_W + 1;

    localparam logic [SCNT_W-1:0] SYNC_FULL = SCNT_W'(SYNC_W);
    localparam logic [SCNT_W-1:0] SYNC_MIN  = SCNT_W'(SYNC_W - 1);
    localparam logic [HCNT_W-1:0] HDR_LAST  = HCNT_W'(HW - 1);
    localparam logic [CHX_W-1:0]  NUM_CH_V  = CHX_W'(NUM_CH);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t              state, state_nxt;
    logic [SYNC_W-1:0]   hist, hist_nxt;
    logic [SCNT_W-1:0]   scnt, scnt_nxt;
    logic [HCNT_W-1:0]   hcnt, hcnt_nxt;
    logic [HW-2:0]       hdr_sh, hdr_sh_nxt;
    logic [LEN_W-1:0]    dcnt, dcnt_nxt;
    logic [CH_W-1:0]     cur_ch_r, cur_ch_nxt;
    logic [LEN_W-1:0]    cur_len_r, cur_len_nxt;

    logic [SYNC_W-1:0]   hist_shift;
    logic [HW-1:0]       hdr_full;
    logic                ch_ok;
    logic                done_c, err_c;

    // The current bit takes part in both the sync compare and the final header edge.
    assign hist_shift = {hist[SYNC_W-2:0], bus.ser_in};
    assign hdr_full   = {hdr_sh, bus.ser_in};
    assign ch_ok      = ({1'b0, cur_ch_r} < NUM_CH_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hist      <= '0;
            scnt      <= '0;
            hcnt      <= '0;
            hdr_sh    <= '0;
            dcnt      <= '0;
            cur_ch_r  <= '0;
            cur_len_r <= '0;
        end else begin
            state     <= state_nxt;
            hist      <= hist_nxt;
            scnt      <= scnt_nxt;
            hcnt      <= hcnt_nxt;
            hdr_sh    <= hdr_sh_nxt;
            dcnt      <= dcnt_nxt;
            cur_ch_r  <= cur_ch_nxt;
            cur_len_r <= cur_len_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hist_nxt    = hist;
        scnt_nxt    = scnt;
        hcnt_nxt    = hcnt;
        hdr_sh_nxt  = hdr_sh;
        dcnt_nxt    = dcnt;
        cur_ch_nxt  = cur_ch_r;
        cur_len_nxt = cur_len_r;
        done_c      = 1'b0;
        err_c       = 1'b0;

        case (state)
            IDLE: begin
                hist_nxt = hist_shift;
                if (scnt != SYNC_FULL) begin
                    scnt_nxt = scnt + 1'b1;
                end
                if ((scnt >= SYNC_MIN) && (hist_shift == SYNC_PAT)) begin
                    state_nxt = HDR;
                    hcnt_nxt  = '0;
                    hist_nxt  = '0;
                    scnt_nxt  = '0;
                end
            end
            HDR: begin
                hdr_sh_nxt = hdr_full[HW-2:0];
                hcnt_nxt   = hcnt + 1'b1;
                if (hcnt == HDR_LAST) begin
                    cur_ch_nxt  = hdr_full[HW-1 -: CH_W];
                    cur_len_nxt = hdr_full[LEN_W-1:0];
                    dcnt_nxt    = '0;
                    state_nxt   = (hdr_full[LEN_W-1:0] == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                dcnt_nxt = dcnt + 1'b1;
                if (dcnt == cur_len_r - 1'b1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                err_c     = ~ch_ok;
                state_nxt = IDLE;
                hist_nxt  = '0;
                scnt_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything, including a header that would complete this edge.
        if (bus.abort) begin
            state_nxt   = IDLE;
            hist_nxt    = '0;
            scnt_nxt    = '0;
            cur_ch_nxt  = cur_ch_r;
            cur_len_nxt = cur_len_r;
            done_c      = 1'b0;
            err_c       = 1'b0;
        end
    end

    always_comb begin
        bus.ser_out       = '0;
        bus.ser_out_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state == DATA) && ch_ok && (cur_ch_r == CH_W'(i))) begin
                bus.ser_out_valid[i] = 1'b1;
                bus.ser_out[i]       = bus.ser_in;
            end
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_c;
    assign bus.err     = err_c;
    assign bus.cur_ch  = cur_ch_r;
    assign bus.cur_len = cur_len_r;
endmodule

// File: doc/serial_packet_demux.md
Name: serial_packet_demux

Overview:
Parametrised serial packet receiver and demultiplexer. It hunts for a configurable sync pattern on a 1-bit serial line, then shifts in a header holding the channel index and payload length. It routes the following payload bits to one of NUM_CH serial output lanes with a per-lane valid. It supersedes the fixed 8-bit-header receiver FSM in the serial-link datapath and adds a length field, variable channel count, zero-length packets, abort, and error reporting.

Parameters:
SYNC_W, 4, width of the sync pattern in bits
SYNC_PAT, 4'b1101, sync pattern, first-received bit is the MSB
NUM_CH, 4, number of output lanes (≥2, need not be a power of 2)
CH_W, $clog2(NUM_CH), width of the channel field in the header
LEN_W, 4, width of the payload-length field in the header

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
ser_in  input  1  serial data, sampled on every rising clk edge
abort  input  1  synchronous abort, returns FSM to IDLE
ser_out  output  NUM_CH  per-lane data; lane cur_ch carries ser_in during DATA, all other lanes 0
ser_out_valid  output  NUM_CH  one-hot lane valid during DATA, otherwise 0
busy  output  1  high in HDR, DATA, DONE
done  output  1  one-cycle pulse at packet end
err  output  1  one-cycle pulse with done when channel index ≥ NUM_CH
cur_ch  output  CH_W  latched channel index
cur_len  output  LEN_W  latched payload length

Behaviour:
- Reset (async): state=IDLE, sync history cleared, bit counters 0, cur_ch=0, cur_len=0. All outputs are 0.
- States: IDLE, HDR, DATA, DONE, held in a registered state with combinational next-state logic. Every output has a default assignment in every state, so no latches are inferred.
- IDLE:
  - Shift ser_in into a SYNC_W-bit history and count received bits, saturating at SYNC_W.
  - A match requires at least SYNC_W bits received since entering IDLE and history==SYNC_PAT including the current bit. Overlapping prefixes are allowed.
  - On a match at edge k, go to HDR.
- HDR:
  - Shift in CH_W+LEN_W bits MSB-first, channel field first, on edges k+1..k+CH_W+LEN_W.
  - On the last header edge, latch cur_ch and cur_len.
  - If length==0, go to DONE; otherwise go to DATA.
- DATA:
  - Lasts exactly cur_len cycles.
  - If cur_ch<NUM_CH: ser_out_valid[cur_ch]=1 and ser_out[cur_ch]=ser_in, combinational pass-through with zero latency.
  - If cur_ch≥NUM_CH: all lanes stay 0 and the payload is discarded, still for cur_len cycles.
  - After the cur_len-th bit edge, go to DONE.
- DONE:
  - Lasts one cycle. done=1, and err=1 if cur_ch≥NUM_CH.
  - Next state is IDLE, with sync history and count cleared. Bits in DONE are ignored.
- abort=1 in any state: next state is IDLE with history cleared. No done or err pulse. cur_ch and cur_len keep their last values. abort in IDLE just clears the history.
- rst mid-packet: immediate return to the reset state. Outputs drop asynchronously.
- Counters: header counter has width $clog2(CH_W+LEN_W+1); payload counter has width LEN_W. There is no wrap beyond the maximum length 2^LEN_W−1.
- busy = (state != IDLE).

Test Plan:
- Defaults; stream 0000,1101, header 10 0011, data 101 → HDR entered after the 4th sync bit. ser_out_valid=4'b0100 for exactly 3 cycles; ser_out[2] = 1,0,1 and other lanes 0; done pulses 1 cycle after the last data bit; then IDLE.
- Sync 1101, header 01 0000 → no DATA cycles. done pulses the cycle after the last header bit; ser_out_valid stays 0; cur_ch=1, cur_len=0.
- Stream 1111101 → single match on the final bit, by overlap. A following header 11 0001 with data 1 gives ser_out_valid=4'b1000 for 1 cycle.
- Assert abort in the 2nd DATA cycle of a len=5 packet → valid drops next cycle, no done. A fresh 1101 followed by a header is received correctly.
- Assert rst mid-HDR → all outputs 0 immediately. After release, the first 3 bits after reset never match even if they end in 101.
- NUM_CH=3 (CH_W=2); sync then header 11 0010 → 2 DATA cycles with ser_out_valid=0; done=1 and err=1 together for one cycle.
